// File: rtl/hilo_unit.sv
// hilo_unit
// Architectural HI/LO register pair with a two-slot pending-write pipeline
// (M slot, then W slot) ahead of the committed registers. The read port
// forwards the youngest pending write for each half, so a mfhi/mflo in EX
// sees a mult/div/mthi/mtlo issued one or two cycles earlier without a stall.
//
// Ports:
//   clk      clock, all state updates on the rising edge
//   rst      synchronous active-high reset, overrides stall
//   stall    freezes every register
//   flush_m  kills the write currently held in the M slot
//   ex_whl   write both halves from ex_hi / ex_lo (wins over mthi/mtlo)
//   ex_lo    low result from the ALU
//   ex_hi    high result from the ALU
//   ex_mthi  write HI from ex_src
//   ex_mtlo  write LO from ex_src
//   ex_src   rs operand for mthi/mtlo
//   rd_hi    read select, 1 = HI, 0 = LO
//   rd_data  forwarded value of the selected half (combinational)
//   hi, lo   committed registers
module hilo_unit #(
   parameter int N = 32
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         stall,
   input  logic         flush_m,
   input  logic         ex_whl,
   input  logic [N-1:0] ex_lo,
   input  logic [N-1:0] ex_hi,
   input  logic         ex_mthi,
   input  logic         ex_mtlo,
   input  logic [N-1:0] ex_src,
   input  logic         rd_hi,
   output logic [N-1:0] rd_data,
   output logic [N-1:0] hi,
   output logic [N-1:0] lo
);

   // Index 1 is the HI half, index 0 is the LO half. Both halves run the
   // same pipeline, differing only in which ALU word and which mt* strobe
   // feed them.
   logic [N-1:0] ex_word  [2];
   logic         ex_mt    [2];
   logic [N-1:0] fwd_half [2];
   logic [N-1:0] com_half [2];

   assign ex_word[0] = ex_lo;
   assign ex_word[1] = ex_hi;
   assign ex_mt[0]   = ex_mtlo;
   assign ex_mt[1]   = ex_mthi;

   genvar gi;
   generate
      for (gi = 0; gi < 2; gi++) begin : g_half
         logic         m_v_reg;
         logic [N-1:0] m_d_reg;
         logic         w_v_reg;
         logic [N-1:0] w_d_reg;
         logic [N-1:0] c_reg;
         logic         cap_v_next;
         logic [N-1:0] cap_d_next;

         // ex_whl takes priority over the mt* strobes. If both mthi and
         // mtlo are set, each half independently picks up ex_src, which
         // gives the "write both from ex_src" behaviour for free.
         always_comb begin
            cap_v_next = ex_whl | ex_mt[gi];
            cap_d_next = ex_whl ? ex_word[gi] : ex_src;
         end

         always_ff @(posedge clk) begin
            if (rst) begin
               m_v_reg <= 1'b0;
               m_d_reg <= '0;
               w_v_reg <= 1'b0;
               w_d_reg <= '0;
               c_reg   <= '0;
            end else if (!stall) begin
               m_v_reg <= cap_v_next;
               m_d_reg <= cap_d_next;
               // An exception in MEM only cancels the valid; the data
               // moving into W is never looked at without it.
               w_v_reg <= m_v_reg & ~flush_m;
               w_d_reg <= m_d_reg;
               if (w_v_reg) begin
                  c_reg <= w_d_reg;
               end
            end
         end

         // Youngest valid write wins. EX inputs are deliberately not
         // forwarded: the reader is the EX instruction itself.
         assign fwd_half[gi] = m_v_reg ? m_d_reg :
                               w_v_reg ? w_d_reg : c_reg;
         assign com_half[gi] = c_reg;
      end
   endgenerate

   assign rd_data = rd_hi ? fwd_half[1] : fwd_half[0];
   assign hi      = com_half[1];
   assign lo      = com_half[0];

endmodule

// File: tb/tb_hilo_unit.sv
// Testbench for hilo_unit. The reference model is an architectural view:
// committed HI/LO plus an ordered list of in-flight writes, each tagged with
// how many unstalled edges it has survived. A read returns the newest
// in-flight write touching that half, else the committed value. After every
// edge the expected outputs are queued; a negedge monitor pops and compares.
module tb_hilo_unit;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        stall = 1'b0;
   logic        flush_m = 1'b0;
   logic        ex_whl = 1'b0;
   logic [31:0] ex_lo = '0;
   logic [31:0] ex_hi = '0;
   logic        ex_mthi = 1'b0;
   logic        ex_mtlo = 1'b0;
   logic [31:0] ex_src = '0;
   logic        rd_hi = 1'b0;
   logic [31:0] rd_data;
   logic [31:0] hi;
   logic [31:0] lo;

   hilo_unit #(.N(32)) dut (
      .clk     (clk),
      .rst     (rst),
      .stall   (stall),
      .flush_m (flush_m),
      .ex_whl  (ex_whl),
      .ex_lo   (ex_lo),
      .ex_hi   (ex_hi),
      .ex_mthi (ex_mthi),
      .ex_mtlo (ex_mtlo),
      .ex_src  (ex_src),
      .rd_hi   (rd_hi),
      .rd_data (rd_data),
      .hi      (hi),
      .lo      (lo)
   );

   always #5 clk = ~clk;

   int checks = 0;
   int errors = 0;

   typedef struct {
      bit          vh;
      bit          vl;
      logic [31:0] h;
      logic [31:0] l;
      int          age;
   } pend_t;

   typedef struct {
      logic [31:0] rd;
      logic [31:0] h;
      logic [31:0] l;
   } exp_t;

   pend_t       pend [$];
   exp_t        exp_q [$];
   logic [31:0] arch_hi = '0;
   logic [31:0] arch_lo = '0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] want);
      checks++;
      if (act !== want) begin
         errors++;
         $display("FAIL %s got %h want %h", name, act, want);
      end
   endtask

   function automatic logic [31:0] model_read(input bit h);
      for (int i = pend.size() - 1; i >= 0; i--) begin
         if (h && pend[i].vh) return pend[i].h;
         if (!h && pend[i].vl) return pend[i].l;
      end
      return h ? arch_hi : arch_lo;
   endfunction

   // Applies the inputs that were live at the edge just taken.
   task automatic model_edge();
      pend_t p;
      if (rst) begin
         pend.delete();
         arch_hi = '0;
         arch_lo = '0;
      end else if (!stall) begin
         // A write that has already survived one edge retires now.
         if (pend.size() > 0 && pend[0].age == 1) begin
            p = pend.pop_front();
            if (p.vh) arch_hi = p.h;
            if (p.vl) arch_lo = p.l;
         end
         // The write captured on the previous edge either dies or ages.
         if (pend.size() > 0) begin
            p = pend.pop_front();
            if (!flush_m) begin
               p.age = 1;
               pend.push_front(p);
            end
         end
         if (ex_whl) begin
            p = '{vh: 1'b1, vl: 1'b1, h: ex_hi, l: ex_lo, age: 0};
            pend.push_back(p);
         end else if (ex_mthi || ex_mtlo) begin
            p = '{vh: ex_mthi, vl: ex_mtlo, h: ex_src, l: ex_src, age: 0};
            pend.push_back(p);
         end
      end
   endtask

   // Wait for an edge, update the model, drive inputs for the next edge,
   // then queue the expected outputs for the state just reached.
   task automatic step(input bit r, input bit s, input bit f, input bit w,
                       input logic [31:0] hv, input logic [31:0] lv,
                       input bit mh, input bit ml, input logic [31:0] sv,
                       input bit rh);
      exp_t e;
      @(posedge clk);
      #1;
      model_edge();
      rst = r; stall = s; flush_m = f; ex_whl = w;
      ex_hi = hv; ex_lo = lv; ex_mthi = mh; ex_mtlo = ml; ex_src = sv;
      rd_hi = rh;
      #1;
      e.rd = model_read(rh);
      e.h  = arch_hi;
      e.l  = arch_lo;
      exp_q.push_back(e);
   endtask

   task automatic idle(input bit rh);
      step(0, 0, 0, 0, 32'h0, 32'h0, 0, 0, 32'h0, rh);
   endtask

   always @(negedge clk) begin
      exp_t e;
      if (exp_q.size() != 0) begin
         e = exp_q.pop_front();
         chk("sb_rd_data", rd_data, e.rd);
         chk("sb_hi", hi, e.h);
         chk("sb_lo", lo, e.l);
      end
   end

   initial begin
      bit          r, s, f, w, mh, ml, rh;
      int          op;
      logic [31:0] hv, lv, sv;
      int          wait_cnt;

      // Reset, then a mult-style write of both halves.
      step(1, 0, 0, 0, 32'h0, 32'h0, 0, 0, 32'h0, 1);
      step(0, 0, 0, 1, 32'h0000_0001, 32'hFFFF_FFFE, 0, 0, 32'h0, 1);
      chk("reset_rd", rd_data, 32'h0);
      chk("reset_hi", hi, 32'h0);
      idle(1);
      chk("whl_fwd_hi", rd_data, 32'h1);
      chk("whl_hi_not_yet", hi, 32'h0);
      idle(0);
      chk("whl_fwd_lo_w", rd_data, 32'hFFFF_FFFE);
      idle(1);
      chk("whl_commit_hi", hi, 32'h1);
      chk("whl_commit_lo", lo, 32'hFFFF_FFFE);

      // mthi then mtlo on consecutive cycles.
      step(0, 0, 0, 0, 32'h0, 32'h0, 1, 0, 32'hAAAA_0000, 1);
      step(0, 0, 0, 0, 32'h0, 32'h0, 0, 1, 32'h0000_5555, 1);
      chk("mthi_fwd", rd_data, 32'hAAAA_0000);
      idle(0);
      chk("mtlo_fwd", rd_data, 32'h0000_5555);
      chk("mthi_hi_pending", hi, 32'h1);
      idle(1);
      chk("mthi_fwd_commit", rd_data, 32'hAAAA_0000);
      chk("mthi_commit", hi, 32'hAAAA_0000);
      chk("mtlo_not_yet", lo, 32'hFFFF_FFFE);
      idle(0);
      chk("mtlo_commit", lo, 32'h0000_5555);

      // Write killed in MEM.
      step(1, 0, 0, 0, 32'h0, 32'h0, 0, 0, 32'h0, 1);
      step(0, 0, 0, 1, 32'h5, 32'h7, 0, 0, 32'h0, 1);
      step(0, 0, 1, 0, 32'h0, 32'h0, 0, 0, 32'h0, 1);
      chk("flush_pre_fwd", rd_data, 32'h5);
      idle(0);
      chk("flush_rd_lo", rd_data, 32'h0);
      idle(1);
      chk("flush_rd_hi", rd_data, 32'h0);
      idle(1);
      chk("flush_hi", hi, 32'h0);
      chk("flush_lo", lo, 32'h0);

      // Same-half writes back to back.
      step(0, 0, 0, 0, 32'h0, 32'h0, 1, 0, 32'h3, 1);
      step(0, 0, 0, 0, 32'h0, 32'h0, 1, 0, 32'h9, 1);
      idle(1);
      chk("m_over_w", rd_data, 32'h9);
      chk("b2b_hi0", hi, 32'h0);
      idle(1);
      chk("b2b_hi3", hi, 32'h3);
      idle(1);
      chk("b2b_hi9", hi, 32'h9);

      // Stall holding a pending mtlo.
      step(0, 0, 0, 0, 32'h0, 32'h0, 0, 1, 32'h12, 0);
      step(0, 1, 0, 0, 32'h0, 32'h0, 0, 0, 32'h0, 0);
      chk("stall_fwd0", rd_data, 32'h12);
      step(0, 1, 1, 1, 32'hBAD0, 32'hBAD1, 0, 0, 32'h0, 0);
      chk("stall_fwd1", rd_data, 32'h12);
      step(0, 1, 0, 0, 32'h0, 32'h0, 0, 0, 32'h0, 0);
      chk("stall_fwd2", rd_data, 32'h12);
      idle(0);
      chk("stall_fwd3", rd_data, 32'h12);
      chk("stall_lo_held", lo, 32'h0);
      idle(0);
      chk("stall_lo_rel1", lo, 32'h0);
      idle(0);
      chk("stall_lo_rel2", lo, 32'h12);

      // Reset under stall discards the pending HI write.
      step(0, 0, 0, 0, 32'h0, 32'h0, 1, 0, 32'hDEAD, 1);
      idle(1);
      step(1, 1, 0, 0, 32'h0, 32'h0, 0, 0, 32'h0, 1);
      chk("pre_rst_fwd", rd_data, 32'hDEAD);
      idle(1);
      chk("rst_stall_hi", hi, 32'h0);
      chk("rst_stall_rd", rd_data, 32'h0);
      idle(1);
      idle(1);
      chk("rst_never_dead", hi, 32'h0);

      // Random traffic.
      for (int i = 0; i < 400; i++) begin
         r  = ($urandom_range(0, 59) == 0);
         s  = ($urandom_range(0, 5) == 0);
         f  = ($urandom_range(0, 6) == 0);
         op = $urandom_range(0, 5);
         w  = (op == 1);
         mh = (op == 2) || (op == 4) || (op == 5 && $urandom_range(0, 1) == 1);
         ml = (op == 3) || (op == 4);
         hv = $urandom();
         lv = $urandom();
         sv = ($urandom_range(0, 1) == 1) ? $urandom() : 32'($urandom_range(0, 15));
         rh = $urandom_range(0, 1);
         step(r, s, f, w, hv, lv, mh, ml, sv, rh);
      end
      idle(1);
      idle(0);

      wait_cnt = 0;
      while (exp_q.size() != 0 && wait_cnt < 20) begin
         @(posedge clk);
         wait_cnt++;
      end
      checks++;
      if (exp_q.size() != 0) begin
         errors++;
         $display("FAIL drain got %0d pending want 0", exp_q.size());
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/hilo_unit.md
# hilo_unit

Architectural HI/LO register pair with a two-slot pending-write pipeline, sitting directly downstream of the ALU. Captures the ALU's mult/div results (low word `F`, high word `FF`, write strobe `whl`) and mthi/mtlo data in EX, carries them through MEM and WB slots, and commits them at the end of WB. Provides a forwarded combinational read port for mfhi/mflo in EX, so back-to-back HI/LO producer/consumer pairs need no stall.

## Interface
- `N`, default 32: data width.

- `clk`  in  1  clock; all state updates on rising edge.
- `rst`  in  1  synchronous, active-high reset.
- `stall`  in  1  freezes all state (no capture, no advance, no commit).
- `flush_m`  in  1  kills the MEM-slot write (exception in MEM).
- `ex_whl`  in  1  ALU write strobe; write both HI and LO.
- `ex_lo`  in  N  ALU low result (`F`: product low word or quotient).
- `ex_hi`  in  N  ALU high result (`FF`: product high word or remainder).
- `ex_mthi`  in  1  write HI from `ex_src`.
- `ex_mtlo`  in  1  write LO from `ex_src`.
- `ex_src`  in  N  rs value for mthi/mtlo.
- `rd_hi`  in  1  read select: 1 = HI, 0 = LO.
- `rd_data`  out  N  forwarded HI or LO value, combinational.
- `hi`  out  N  committed HI.
- `lo`  out  N  committed LO.

## Operation
- State: M slot `{m_vh, m_vl, m_hi, m_lo}`, W slot `{w_vh, w_vl, w_hi, w_lo}`, committed `hi`, `lo`.
- EX capture on edge, when `stall`=0:
  - `ex_whl`=1: `m_vh`=`m_vl`=1, `m_hi`=`ex_hi`, `m_lo`=`ex_lo`. This takes priority; `ex_mthi`/`ex_mtlo` are ignored.
  - Otherwise `ex_mthi`: `m_vh`=1, `m_hi`=`ex_src`.
  - Otherwise `ex_mtlo`: `m_vl`=1, `m_lo`=`ex_src`.
  - Both `ex_mthi` and `ex_mtlo` (illegal encoding): write both from `ex_src`.
  - None asserted: M valids become 0. Data is don't-care.
- Advance on edge, when `stall`=0:
  - W slot takes the M slot. If `flush_m`=1, W valids become 0 instead.
  - `hi` takes `w_hi` if `w_vh`; `lo` takes `w_lo` if `w_vl`. Otherwise both hold.
- `flush_m` affects only the M slot. W commits normally. The EX capture in the same cycle still occurs; upstream kills EX itself.
- `stall`=1: every register holds, including on `flush_m`. `flush_m` is sampled only when `stall`=0.
- Read forwarding, per half independently:
  - HI: `m_vh` ? `m_hi` : `w_vh` ? `w_hi` : `hi`.
  - LO: same order using `m_vl`, `w_vl`, `lo`.
  - `rd_data` is the selected half. The EX-stage inputs are never forwarded, because the reader is the EX instruction itself.
  - A flushed M slot (valid=0) is never forwarded.
- No arithmetic is performed. All values are N-bit pass-through. Signedness is resolved in the ALU.

## Timing
- `rst`=1 at an edge: all valids 0, all data 0, `hi`=`lo`=0, so `rd_data`=0. `rst` overrides `stall`. Reset mid-operation discards all pending writes.
- Commit latency: a write sampled at edge k is in M after k, in W after k+1, and visible on `hi`/`lo` after k+2 (with no stall).
- Forward latency: the write is visible on `rd_data` immediately after edge k.
- Same-half writes in consecutive cycles: the younger write (M) wins on `rd_data`, and commits in program order.
- Simultaneous commit of W and capture into M in one edge is legal, with no conflict.
- `rd_data` and `hi`/`lo` have no output registers; `rd_data` is a combinational function of state and `rd_hi` only.

## Test plan
- Reset, then `ex_whl`=1, `ex_hi`=32'h0000_0001, `ex_lo`=32'hFFFF_FFFE for one cycle:
  - `rd_data` (with `rd_hi`=1) = 1 the cycle after.
  - `hi`=1 and `lo`=32'hFFFF_FFFE two edges later.
- mthi 32'hAAAA_0000, then the next cycle mtlo 32'h0000_5555:
  - `rd_hi`=1 gives AAAA_0000 and `rd_hi`=0 gives 0000_5555 after the second edge.
  - `hi` and `lo` update on successive edges.
- `ex_whl` with hi=5/lo=7, then `flush_m`=1 on the next cycle:
  - `rd_data` returns 0 for both halves.
  - `hi`/`lo` remain 0 permanently.
- mthi 3, then mthi 9 next cycle:
  - `rd_data` (`rd_hi`=1) = 9 (M over W).
  - Committed `hi` goes 3 then 9.
- Pending mtlo 0x12 in M, `stall`=1 for 3 cycles:
  - `rd_data` stays 0x12 and `lo` stays 0.
  - After release, `lo` = 0x12 two edges later.
- `rst` asserted while W holds a pending HI=0xDEAD with `stall`=1:
  - `hi`=0, `rd_data`=0 next cycle.
  - 0xDEAD never appears.
